// File: rtl/bram_pkg.sv
// Shared types and default geometry for the single-port block RAM.
package bram_pkg;

  typedef enum logic [1:0] {
    WRITE_FIRST,
    READ_FIRST,
    NO_CHANGE
  } write_mode_e;

  localparam int unsigned DefAddrWidth   = 6;
  localparam int unsigned DefDataWidth   = 8;
  localparam int unsigned DefReadLatency = 2;

endpackage

// File: rtl/bram_out_pipe.sv
// Resettable read-data pipeline: stage-1 array register plus an optional output register.
module bram_out_pipe
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned READ_LATENCY = DefReadLatency
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage1_q;

  // load=0 keeps the previous word (NO_CHANGE write cycles)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1_q <= '0;
    end else if (load) begin
      stage1_q <= word;
    end
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= stage1_q;
      end
    end

    assign dout = out_q;
  end else begin : g_no_out_reg
    assign dout = stage1_q;
  end

endmodule

// File: rtl/bram_sp64x8.sv
// Single-port synchronous block RAM with shared read/write address and configurable
// write-cycle read behaviour; one half of the ping-pong double buffer.
module bram_sp64x8
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned READ_LATENCY = DefReadLatency,
  parameter write_mode_e WRITE_MODE   = WRITE_FIRST
) (
  input  logic                  BRAM_PORTA_0_clk,
  input  logic                  BRAM_PORTA_0_rst_n,
  input  logic                  BRAM_PORTA_0_we,
  input  logic [ADDR_WIDTH-1:0] BRAM_PORTA_0_addr,
  input  logic [DATA_WIDTH-1:0] BRAM_PORTA_0_din,
  output logic [DATA_WIDTH-1:0] BRAM_PORTA_0_dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (!(READ_LATENCY inside {1, 2})) begin : g_bad_latency
    $error("bram_sp64x8: READ_LATENCY must be 1 or 2");
  end
  if (!(WRITE_MODE inside {WRITE_FIRST, READ_FIRST, NO_CHANGE})) begin : g_bad_mode
    $error("bram_sp64x8: illegal WRITE_MODE");
  end

  // Configuration-time zero image; reset never touches the array.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_load;

  always_ff @(posedge BRAM_PORTA_0_clk) begin
    if (BRAM_PORTA_0_rst_n && BRAM_PORTA_0_we) begin
      mem[BRAM_PORTA_0_addr] <= BRAM_PORTA_0_din;
    end
  end

  always_comb begin
    rd_word = mem[BRAM_PORTA_0_addr];
    rd_load = 1'b1;
    if (BRAM_PORTA_0_we) begin
      case (WRITE_MODE)
        WRITE_FIRST: rd_word = BRAM_PORTA_0_din;
        NO_CHANGE:   rd_load = 1'b0;
        default:     ;
      endcase
    end
  end

  bram_out_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_out_pipe (
    .clk  (BRAM_PORTA_0_clk),
    .rst_n(BRAM_PORTA_0_rst_n),
    .load (rd_load),
    .word (rd_word),
    .dout (BRAM_PORTA_0_dout)
  );

endmodule

// File: tb/tb_bram_sp64x8.sv
// Self-checking bench: directed scenarios plus randomized traffic against a read-history model.
module tb_bram_sp64x8;
  import bram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] din = '0;
  logic       we_b = 1'b0;
  logic [5:0] addr_b = '0;
  logic [7:0] din_b = '0;
  logic [7:0] dout_a, dout_rf, dout_nc, dout_l1, dout_b;

  int checks = 0;
  int failures = 0;

  // Model: array contents plus, per mode, the word delivered by each edge (newest last).
  logic [7:0] mem_m [64];
  logic [7:0] mem_b [64];
  logic [7:0] h_wf[$];
  logic [7:0] h_rf[$];
  logic [7:0] h_nc[$];
  logic [7:0] h_b[$];
  logic [5:0] rst_addr [3];
  int         a_seq [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7};

  always #5 clk = ~clk;

  bram_sp64x8 #(.READ_LATENCY(2), .WRITE_MODE(WRITE_FIRST)) u_a (
    .BRAM_PORTA_0_clk(clk), .BRAM_PORTA_0_rst_n(rst_n), .BRAM_PORTA_0_we(we),
    .BRAM_PORTA_0_addr(addr), .BRAM_PORTA_0_din(din), .BRAM_PORTA_0_dout(dout_a)
  );
  bram_sp64x8 #(.READ_LATENCY(2), .WRITE_MODE(READ_FIRST)) u_rf (
    .BRAM_PORTA_0_clk(clk), .BRAM_PORTA_0_rst_n(rst_n), .BRAM_PORTA_0_we(we),
    .BRAM_PORTA_0_addr(addr), .BRAM_PORTA_0_din(din), .BRAM_PORTA_0_dout(dout_rf)
  );
  bram_sp64x8 #(.READ_LATENCY(2), .WRITE_MODE(NO_CHANGE)) u_nc (
    .BRAM_PORTA_0_clk(clk), .BRAM_PORTA_0_rst_n(rst_n), .BRAM_PORTA_0_we(we),
    .BRAM_PORTA_0_addr(addr), .BRAM_PORTA_0_din(din), .BRAM_PORTA_0_dout(dout_nc)
  );
  bram_sp64x8 #(.READ_LATENCY(1), .WRITE_MODE(WRITE_FIRST)) u_l1 (
    .BRAM_PORTA_0_clk(clk), .BRAM_PORTA_0_rst_n(rst_n), .BRAM_PORTA_0_we(we),
    .BRAM_PORTA_0_addr(addr), .BRAM_PORTA_0_din(din), .BRAM_PORTA_0_dout(dout_l1)
  );
  bram_sp64x8 #(.READ_LATENCY(2), .WRITE_MODE(WRITE_FIRST)) u_b (
    .BRAM_PORTA_0_clk(clk), .BRAM_PORTA_0_rst_n(rst_n), .BRAM_PORTA_0_we(we_b),
    .BRAM_PORTA_0_addr(addr_b), .BRAM_PORTA_0_din(din_b), .BRAM_PORTA_0_dout(dout_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge from the current inputs, clock, then check all instances.
  task automatic tick();
    logic [7:0] rd;
    logic [7:0] rdb;
    if (!rst_n) begin
      h_wf = {8'h00, 8'h00};
      h_rf = {8'h00, 8'h00};
      h_nc = {8'h00, 8'h00};
      h_b  = {8'h00, 8'h00};
    end else begin
      rd = mem_m[addr];
      h_wf.push_back(we ? din : rd);
      h_rf.push_back(rd);
      h_nc.push_back(we ? h_nc[$] : rd);
      if (we) mem_m[addr] = din;
      rdb = mem_b[addr_b];
      h_b.push_back(we_b ? din_b : rdb);
      if (we_b) mem_b[addr_b] = din_b;
      if (h_wf.size() > 4) begin
        void'(h_wf.pop_front());
        void'(h_rf.pop_front());
        void'(h_nc.pop_front());
        void'(h_b.pop_front());
      end
    end
    @(posedge clk);
    #1;
    check("model_wf_l2", dout_a, h_wf[$-1]);
    check("model_rf_l2", dout_rf, h_rf[$-1]);
    check("model_nc_l2", dout_nc, h_nc[$-1]);
    check("model_wf_l1", dout_l1, h_wf[$]);
    check("model_b_l2", dout_b, h_b[$-1]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 8'h00;
      mem_b[i] = 8'h00;
    end

    // Reset held with writes attempted: dout stays 0, array untouched.
    for (int i = 0; i < 3; i++) begin
      rst_n = 1'b0;
      we = 1'b1;
      addr = 6'($urandom_range(8, 62));
      rst_addr[i] = addr;
      din = 8'($urandom_range(1, 255));
      tick();
      check("reset_hold", dout_a, 8'h00);
    end
    rst_n = 1'b1;
    we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = rst_addr[i % 3];
      tick();
      check("reset_release", dout_a, 8'h00);
    end

    // Sequential fill and drain.
    for (int k = 0; k < 8; k++) begin
      we = 1'b1;
      addr = 6'(k);
      din = 8'(k);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 9; k++) begin
      addr = (k < 8) ? 6'(k) : 6'd0;
      tick();
      if (k >= 1) check("drain", dout_a, 8'(k - 1));
    end

    // Ping-pong: fill A while draining B, then fill B while A runs the prepare sequence.
    for (int k = 0; k < 8; k++) begin
      we = 1'b1;
      addr = 6'(k);
      din = 8'(k);
      we_b = 1'b0;
      addr_b = 6'(k);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      addr = 6'(a_seq[i]);
      we_b = (i < 8);
      addr_b = 6'(i % 8);
      din_b = 8'($urandom);
      tick();
      if (i == 2) check("pp_first", dout_a, 8'h00);
      if (i == 9) check("pp_eighth", dout_a, 8'h07);
    end
    we_b = 1'b0;

    // Write-mode collision on addr 5, with addr 6 read beforehand to pin NO_CHANGE's hold value.
    we = 1'b1; addr = 6'd5; din = 8'h11; tick();
    we = 1'b0; addr = 6'd6; tick();
    we = 1'b1; addr = 6'd5; din = 8'h22; tick();
    check("coll_l1_wf", dout_l1, 8'h22);
    we = 1'b0; addr = 6'd5; tick();
    check("coll_wf", dout_a, 8'h22);
    check("coll_rf", dout_rf, 8'h11);
    check("coll_nc", dout_nc, 8'h06);
    tick();
    check("coll_reread_wf", dout_a, 8'h22);
    check("coll_reread_rf", dout_rf, 8'h22);
    check("coll_reread_nc", dout_nc, 8'h22);

    // Full address range, both latencies.
    we = 1'b1; addr = 6'd63; din = 8'hFF; tick();
    addr = 6'd0; din = 8'hA5; tick();
    we = 1'b0; addr = 6'd63; tick();
    check("range_l1_63", dout_l1, 8'hFF);
    addr = 6'd0; tick();
    check("range_l2_63", dout_a, 8'hFF);
    check("range_l1_0", dout_l1, 8'hA5);
    tick();
    check("range_l2_0", dout_a, 8'hA5);

    // Reset in the middle of a read stream.
    for (int k = 0; k < 3; k++) begin
      addr = 6'(k);
      tick();
    end
    rst_n = 1'b0; addr = 6'd3; tick();
    check("midrst_edge", dout_a, 8'h00);
    rst_n = 1'b1; addr = 6'd4; tick();
    check("midrst_drop", dout_a, 8'h00);
    addr = 6'd5; tick();
    check("midrst_resume", dout_a, 8'h04);
    addr = 6'd3; tick();
    check("midrst_l1_a3", dout_l1, 8'h03);
    tick();
    check("midrst_l2_a3", dout_a, 8'h03);

    // Randomized traffic on a narrow address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      we = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      din = 8'($urandom);
      we_b = 1'($urandom_range(0, 1));
      addr_b = 6'($urandom_range(0, 7));
      din_b = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
